// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with clear, load, saturate and cascade strobes.
// Optional macro MOD_N_COUNTER_BCD_OUT_EN adds a registered two-digit bcd output.
module mod_n_counter #(
  parameter int MODULUS  = 60,
  parameter int WIDTH    = 6,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             borrow,
  output logic             wrap,
  output logic             load_err
`ifdef MOD_N_COUNTER_BCD_OUT_EN
  ,
  output logic [7:0]       bcd
`endif
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam bit SAT_OFF = (SATURATE == 0);

  if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_mod
    $error("mod_n_counter: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             err_nxt;
  logic             at_max;
  logic             at_zero;
  logic             data_ok;
  logic             do_clr;
  logic             do_load;
  logic             do_up;
  logic             do_dn;

  assign at_max  = (q == MAX);
  assign at_zero = (q == '0);
  assign data_ok = (data <= MAX);

  // Mutually exclusive action selects encode clr > load > en.
  assign do_clr  = clr;
  assign do_load = load & ~clr;
  assign do_up   = en & up_dn & ~load & ~clr;
  assign do_dn   = en & ~up_dn & ~load & ~clr;

  // Cascade strobes: zero latency so the next stage advances on the same edge.
  assign carry  = do_up & at_max & rst_n & SAT_OFF;
  assign borrow = do_dn & at_zero & rst_n & SAT_OFF;

  // Next count and pulse values; wrap uses the explicit compare, never overflow.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    unique case (1'b1)
      do_clr: begin
        q_nxt = '0;
      end
      do_load: begin
        if (data_ok) begin
          q_nxt = data;
        end else begin
          q_nxt   = '0;
          err_nxt = 1'b1;
        end
      end
      do_up: begin
        if (!at_max) begin
          q_nxt = q + WIDTH'(1);
        end else if (SAT_OFF) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end
      end
      do_dn: begin
        if (!at_zero) begin
          q_nxt = q - WIDTH'(1);
        end else if (SAT_OFF) begin
          q_nxt    = MAX;
          wrap_nxt = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Count and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= q_nxt;
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

`ifdef MOD_N_COUNTER_BCD_OUT_EN
  if (MODULUS > 100) begin : g_bad_bcd
    $error("mod_n_counter: bcd output needs MODULUS <= 100");
  end

  logic [7:0] bin;
  logic [3:0] tens;
  logic [3:0] ones;

  assign bin  = 8'(q_nxt);
  assign tens = 4'(bin / 8'd10);
  assign ones = 4'(bin % 8'd10);

  // BCD taken from the next count so it lands on the same edge as q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd <= 8'h00;
    end else begin
      bcd <= {tens, ones};
    end
  end
`endif

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter across several parameter sets.
// Checks wrap, borrow, load range, priority, saturate and cascade.
module tb_mod_n_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // MODULUS=60
  logic       r60, en60, ud60, clr60, ld60;
  logic [5:0] d60, q60;
  logic       c60, b60, w60, e60;
  // MODULUS=24
  logic       r24, en24, ud24, clr24, ld24;
  logic [4:0] d24, q24;
  logic       c24, b24, w24, e24;
  // MODULUS=12 saturating
  logic       r12, en12, ud12, clr12, ld12;
  logic [3:0] d12, q12;
  logic       c12, b12, w12, e12;
  // MODULUS=16 = 2**WIDTH
  logic       r16, en16, ud16, clr16, ld16;
  logic [3:0] d16, q16;
  logic       c16, b16, w16, e16;
  // seconds -> minutes cascade
  logic       rc, ens, udc, clrc, lds, ldm;
  logic [5:0] ds, dm, qs, qm;
  logic       cs, bs, ws, es;
  logic       cm, bm, wm, em;
`ifdef MOD_N_COUNTER_BCD_OUT_EN
  logic [7:0] bcd60, bcd24, bcd12, bcd16, bcds, bcdm;
`endif

  mod_n_counter #(.MODULUS(60), .WIDTH(6), .SATURATE(0)) u60 (
    .clk(clk), .rst_n(r60), .en(en60), .up_dn(ud60),
    .clr(clr60), .load(ld60), .data(d60), .q(q60),
    .carry(c60), .borrow(b60), .wrap(w60), .load_err(e60)
`ifdef MOD_N_COUNTER_BCD_OUT_EN
    , .bcd(bcd60)
`endif
  );

  mod_n_counter #(.MODULUS(24), .WIDTH(5), .SATURATE(0)) u24 (
    .clk(clk), .rst_n(r24), .en(en24), .up_dn(ud24),
    .clr(clr24), .load(ld24), .data(d24), .q(q24),
    .carry(c24), .borrow(b24), .wrap(w24), .load_err(e24)
`ifdef MOD_N_COUNTER_BCD_OUT_EN
    , .bcd(bcd24)
`endif
  );

  mod_n_counter #(.MODULUS(12), .WIDTH(4), .SATURATE(1)) u12 (
    .clk(clk), .rst_n(r12), .en(en12), .up_dn(ud12),
    .clr(clr12), .load(ld12), .data(d12), .q(q12),
    .carry(c12), .borrow(b12), .wrap(w12), .load_err(e12)
`ifdef MOD_N_COUNTER_BCD_OUT_EN
    , .bcd(bcd12)
`endif
  );

  mod_n_counter #(.MODULUS(16), .WIDTH(4), .SATURATE(0)) u16 (
    .clk(clk), .rst_n(r16), .en(en16), .up_dn(ud16),
    .clr(clr16), .load(ld16), .data(d16), .q(q16),
    .carry(c16), .borrow(b16), .wrap(w16), .load_err(e16)
`ifdef MOD_N_COUNTER_BCD_OUT_EN
    , .bcd(bcd16)
`endif
  );

  mod_n_counter #(.MODULUS(60), .WIDTH(6), .SATURATE(0)) u_sec (
    .clk(clk), .rst_n(rc), .en(ens), .up_dn(udc),
    .clr(clrc), .load(lds), .data(ds), .q(qs),
    .carry(cs), .borrow(bs), .wrap(ws), .load_err(es)
`ifdef MOD_N_COUNTER_BCD_OUT_EN
    , .bcd(bcds)
`endif
  );

  mod_n_counter #(.MODULUS(60), .WIDTH(6), .SATURATE(0)) u_min (
    .clk(clk), .rst_n(rc), .en(cs), .up_dn(udc),
    .clr(clrc), .load(ldm), .data(dm), .q(qm),
    .carry(cm), .borrow(bm), .wrap(wm), .load_err(em)
`ifdef MOD_N_COUNTER_BCD_OUT_EN
    , .bcd(bcdm)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    r60 = 0; en60 = 0; ud60 = 0; clr60 = 0; ld60 = 0; d60 = '0;
    r24 = 0; en24 = 0; ud24 = 0; clr24 = 0; ld24 = 0; d24 = '0;
    r12 = 0; en12 = 0; ud12 = 0; clr12 = 0; ld12 = 0; d12 = '0;
    r16 = 0; en16 = 0; ud16 = 0; clr16 = 0; ld16 = 0; d16 = '0;
    rc = 0; ens = 0; udc = 1; clrc = 0; lds = 0; ldm = 0;
    ds = '0; dm = '0;
    tick();
    tick();

    // reset state
    chk("rst_q", 32'(q60), 0);
    chk("rst_wrap", 32'(w60), 0);
    chk("rst_err", 32'(e60), 0);
    chk("rst_carry", 32'(c60), 0);
    chk("rst_q24", 32'(q24), 0);
`ifdef MOD_N_COUNTER_BCD_OUT_EN
    chk("rst_bcd", 32'(bcd60), 32'h00);
`endif
    r60 = 1; r24 = 1; r12 = 1; r16 = 1; rc = 1;

    // up wrap on 60
    ld60 = 1; d60 = 6'd58;
    tick();
    chk("ld58_q", 32'(q60), 58);
    chk("ld58_err", 32'(e60), 0);
`ifdef MOD_N_COUNTER_BCD_OUT_EN
    chk("ld58_bcd", 32'(bcd60), 32'h58);
`endif
    ld60 = 0; en60 = 1; ud60 = 1;
    #1;
    chk("c58", 32'(c60), 0);
    tick();
    chk("up59_q", 32'(q60), 59);
    chk("up59_wrap", 32'(w60), 0);
    chk("up59_carry", 32'(c60), 1);
    tick();
    chk("wrap0_q", 32'(q60), 0);
    chk("wrap0_w", 32'(w60), 1);
    chk("wrap0_carry", 32'(c60), 0);
    en60 = 0;
    tick();
    chk("hold_q", 32'(q60), 0);
    chk("wrap_pulse_end", 32'(w60), 0);

    // load range
    ld60 = 1; d60 = 6'd59;
    tick();
    chk("ld59_q", 32'(q60), 59);
    chk("ld59_err", 32'(e60), 0);
    d60 = 6'd63;
    tick();
    chk("ld63_q", 32'(q60), 0);
    chk("ld63_err", 32'(e60), 1);
    d60 = 6'd60;
    tick();
    chk("ld60_q", 32'(q60), 0);
    chk("ld60_err", 32'(e60), 1);
    ld60 = 0;
    tick();
    chk("err_end", 32'(e60), 0);

    // direction change takes effect next edge
    ld60 = 1; d60 = 6'd5;
    tick();
    ld60 = 0; en60 = 1; ud60 = 1;
    tick();
    chk("dir_up", 32'(q60), 6);
    ud60 = 0;
    tick();
    chk("dir_dn", 32'(q60), 5);

    // priority
    r60 = 0; ld60 = 1; d60 = 6'd10; en60 = 1; ud60 = 1;
    tick();
    chk("pri_rst_q", 32'(q60), 0);
    chk("pri_rst_err", 32'(e60), 0);
    r60 = 1; clr60 = 1;
    tick();
    chk("pri_clr_q", 32'(q60), 0);
    d60 = 6'd63;
    tick();
    chk("pri_clr_noerr", 32'(e60), 0);
    clr60 = 0; d60 = 6'd10;
    tick();
    chk("pri_ld_q", 32'(q60), 10);
    ld60 = 1; d60 = 6'd59;
    tick();
    #1;
    chk("carry_ld_mask", 32'(c60), 0);
    ld60 = 0;
    #1;
    chk("carry_unmask", 32'(c60), 1);
    clr60 = 1;
    #1;
    chk("carry_clr_mask", 32'(c60), 0);
    tick();
    clr60 = 0; en60 = 0;
    chk("clr_nowrap", 32'(w60), 0);

    // down wrap on 24
    clr24 = 1;
    tick();
    clr24 = 0; en24 = 1; ud24 = 0;
    #1;
    chk("b24_at0", 32'(b24), 1);
    tick();
    chk("dn23_q", 32'(q24), 23);
    chk("dn23_w", 32'(w24), 1);
    chk("dn23_b", 32'(b24), 0);
    tick();
    chk("dn22_q", 32'(q24), 22);
    chk("dn22_w", 32'(w24), 0);
    tick();
    chk("dn21_q", 32'(q24), 21);
    en24 = 0;

    // saturate on 12
    ld12 = 1; d12 = 4'd11;
    tick();
    ld12 = 0; en12 = 1; ud12 = 1;
    #1;
    chk("sat_carry", 32'(c12), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_up_q", 32'(q12), 11);
      chk("sat_up_w", 32'(w12), 0);
    end
    en12 = 0; ld12 = 1; d12 = 4'd0;
    tick();
    ld12 = 0; en12 = 1; ud12 = 0;
    #1;
    chk("sat_borrow", 32'(b12), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_dn_q", 32'(q12), 0);
      chk("sat_dn_w", 32'(w12), 0);
    end
    en12 = 0;
    ld12 = 1; d12 = 4'd12;
    tick();
    ld12 = 0;
    chk("ld12_err", 32'(e12), 1);

    // full power-of-two modulus
    ld16 = 1; d16 = 4'd15;
    tick();
    chk("ld15_err", 32'(e16), 0);
    ld16 = 0; en16 = 1; ud16 = 1;
    #1;
    chk("c16", 32'(c16), 1);
    tick();
    chk("w16_up_q", 32'(q16), 0);
    chk("w16_up_w", 32'(w16), 1);
    ud16 = 0;
    #1;
    chk("b16", 32'(b16), 1);
    tick();
    chk("w16_dn_q", 32'(q16), 15);
    chk("w16_dn_w", 32'(w16), 1);
    en16 = 0;

    // cascade seconds -> minutes
    lds = 1; ds = 6'd59; ldm = 1; dm = 6'd7;
    tick();
    lds = 0; ldm = 0; ens = 1; udc = 1;
    #1;
    chk("cas_carry", 32'(cs), 1);
    tick();
    chk("cas_sec", 32'(qs), 0);
    chk("cas_min", 32'(qm), 8);
    chk("cas_sec_w", 32'(ws), 1);
    chk("cas_min_w", 32'(wm), 0);
`ifdef MOD_N_COUNTER_BCD_OUT_EN
    chk("cas_bcd_s", 32'(bcds), 32'h00);
    chk("cas_bcd_m", 32'(bcdm), 32'h08);
`endif
    ens = 0;
    lds = 1; ds = 6'd59; ldm = 1; dm = 6'd59;
    tick();
`ifdef MOD_N_COUNTER_BCD_OUT_EN
    chk("cas_bcd_59", 32'(bcdm), 32'h59);
`endif
    lds = 0; ldm = 0; ens = 1;
    tick();
    chk("both_sec", 32'(qs), 0);
    chk("both_min", 32'(qm), 0);
    chk("both_ws", 32'(ws), 1);
    chk("both_wm", 32'(wm), 1);
    ens = 0;
    tick();
    chk("both_wm_end", 32'(wm), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
